l1tlb_miss_tracker: RTL and testbench
=====================================

Name: l1tlb_miss_tracker

Overview:
- Sits in the L1TLB, directly upstream of the L2TLB.
- Takes L1TLB lookup misses and allocates one tracking entry per distinct virtual page; the entry index is the request id (rid).
- Issues one L2TLB request per entry, matches returning L2TLB acks by rid, and delivers registered fills back to the L1TLB array.
- Duplicate misses to an in-flight page merge into the existing entry without a second request.

Parameters:
- ENTRIES, 4, number of outstanding distinct-page misses (power of 2, 2..8).
- RID_W, 2, rid width; equals log2(ENTRIES).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- miss_valid  in  1  L1TLB lookup miss
- miss_retry  out  1  miss not accepted this cycle
- miss_laddr  in  39  faulting logical address
- l1tlbtol2tlb_req_valid  out  1  request to L2TLB
- l1tlbtol2tlb_req_retry  in  1  L2TLB back-pressure
- l1tlbtol2tlb_req_rid  out  RID_W  entry index
- l1tlbtol2tlb_req_laddr  out  39  {vpn, 12'b0}
- l2tlbtol1tlb_ack_valid  in  1  translation return
- l2tlbtol1tlb_ack_retry  out  1  ack back-pressure
- l2tlbtol1tlb_ack_rid  in  RID_W  returning entry
- l2tlbtol1tlb_ack_hpaddr  in  11  hashed page address
- l2tlbtol1tlb_ack_ppaddr  in  3  partial page address
- l2tlbtol1tlb_ack_dctlbe  in  13  permission/ctl bits
- fill_valid  out  1  fill to L1TLB array
- fill_retry  in  1  array busy
- fill_vpn  out  27  laddr[38:12] of the filled page
- fill_hpaddr  out  11  as acked
- fill_ppaddr  out  3  as acked
- fill_dctlbe  out  13  as acked
- busy  out  1  any entry not FREE
- err_bad_rid  out  1  sticky: ack arrived for an entry not in WAIT

Behaviour:
- Handshake: a transfer occurs on valid && !retry. Valid and payload hold until transfer. Retry never depends combinationally on the same interface's valid.
- Per-entry state: FREE -> PEND -> WAIT -> FREE. Each entry stores vpn = laddr[38:12] (27 bits).
  - FREE->PEND: miss accepted into this entry.
  - PEND->WAIT: request transfers for this entry.
  - WAIT->FREE: ack transfers with this entry's rid.
- Miss handling, evaluated on registered state:
  - match = some entry is not FREE, its vpn equals miss vpn, and it is not being freed this cycle.
  - match: the miss is accepted and merged; no new entry, no new request.
  - else if a FREE entry exists: allocate the lowest-index FREE entry.
  - else miss_retry = 1.
  - miss_retry = !match && no FREE entry. An entry freed this cycle is not allocatable until the next cycle.
- Issue:
  - l1tlbtol2tlb_req_valid = any PEND.
  - Select the lowest-index PEND entry. The selection is held stable while retried; a lower-index entry becoming PEND does not preempt it.
  - The request is combinational from registers. A miss accepted in cycle N gives req_valid in cycle N+1 at the earliest.
- Ack and fill:
  - l2tlbtol1tlb_ack_retry = fill_valid && fill_retry. This is a single output register, no skid.
  - An ack accepted in cycle M loads the fill register (vpn from the entry, other fields from the ack), so fill_valid rises in cycle M+1. The entry becomes FREE in cycle M+1.
  - A fill transfer and a new ack in the same cycle reload the register with no bubble.
- Bad rid: an ack whose rid entry is not WAIT is accepted and dropped. It produces no fill, sets err_bad_rid, and changes no state.
- Simultaneous: a miss matching the entry being freed by a concurrent ack is not merged; it allocates a different FREE entry or is retried.
- Reset: asynchronous. All entries FREE; req_valid, fill_valid, err_bad_rid, busy = 0; miss_retry = 0. All in-flight state is discarded. An ack arriving after reset deasserts is treated as a bad rid.
- Widths: vpn compares are exact 27-bit equality. rid is exactly the entry index; there is no wrap logic.

Decomposition:
- scmem package additions:
  - I_l1tlbtol2tlb_req_type {rid, laddr}
  - I_l2tlbtol1tlb_ack_type {rid, hpaddr, ppaddr, dctlbe}
  - L1TLB_VPN_W = 27
  - enum l1tlb_mshr_state_t {FREE, PEND, WAIT}.
- The fill output register reuses the existing fflop. No other sub-module.

Test Plan:
1. Single miss laddr 0x12_3456_7000: req_valid at N+1 with rid 0, laddr 0x12_3456_7000. Ack rid 0, hpaddr 0x155, ppaddr 5, dctlbe 0x1A3 -> next cycle fill vpn 0x123_4567, same fields; busy drops.
2. Merge: misses 0x4000 and 0x4ABC on consecutive cycles -> exactly one request, one fill, vpn 0x4.
3. Full: 4 distinct misses are accepted, the 5th distinct miss sees miss_retry = 1. A 5th miss to an in-flight page is accepted. After ack rid 2, the next distinct miss allocates entry 2 one cycle later.
4. Back-pressure: l1tlbtol2tlb_req_retry held 3 cycles with entries 1 and 3 PEND -> rid 1 held stable, then 1 then 3 issued. fill_retry held while a second ack arrives -> ack_retry = 1 until the fill drains, with no loss.
5. Ack rid 3 while entry 3 is FREE -> no fill, err_bad_rid = 1 and stays set.
6. Reset asserted mid-flight with 2 WAIT entries -> all outputs 0 immediately. After release, a new miss allocates rid 0.

Source files
------------

// File: rtl/l1tlb_miss_tracker_pkg.sv
// Shared types and widths for the L1TLB miss tracker: request/ack/fill payloads and the
// per-entry tracking state.
package l1tlb_miss_tracker_pkg;

    localparam int L1TLB_LADDR_W  = 39;
    localparam int L1TLB_VPN_W    = 27;
    localparam int L1TLB_PGOFF_W  = L1TLB_LADDR_W - L1TLB_VPN_W;
    localparam int L1TLB_RID_W    = 2;
    localparam int L1TLB_HPADDR_W = 11;
    localparam int L1TLB_PPADDR_W = 3;
    localparam int L1TLB_DCTLBE_W = 13;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        PEND = 2'd1,
        WAIT = 2'd2
    } l1tlb_mshr_state_t;

    typedef struct packed {
        logic [L1TLB_RID_W-1:0]   rid;
        logic [L1TLB_LADDR_W-1:0] laddr;
    } I_l1tlbtol2tlb_req_type;

    typedef struct packed {
        logic [L1TLB_RID_W-1:0]    rid;
        logic [L1TLB_HPADDR_W-1:0] hpaddr;
        logic [L1TLB_PPADDR_W-1:0] ppaddr;
        logic [L1TLB_DCTLBE_W-1:0] dctlbe;
    } I_l2tlbtol1tlb_ack_type;

    typedef struct packed {
        logic [L1TLB_VPN_W-1:0]    vpn;
        logic [L1TLB_HPADDR_W-1:0] hpaddr;
        logic [L1TLB_PPADDR_W-1:0] ppaddr;
        logic [L1TLB_DCTLBE_W-1:0] dctlbe;
    } l1tlb_fill_t;

    // Page-aligned logical address of a virtual page number.
    function automatic logic [L1TLB_LADDR_W-1:0] vpn_to_laddr(input logic [L1TLB_VPN_W-1:0] vpn);
        return {vpn, {L1TLB_PGOFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/l1tlb_miss_tracker_fflop.sv
// Single-entry valid/retry output register: loads whenever it is empty or draining, so a
// drain and a reload in the same cycle leave no bubble.
module l1tlb_miss_tracker_fflop #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         din_valid_i,
    output logic         din_retry_o,
    input  logic [W-1:0] din_i,
    output logic         q_valid_o,
    input  logic         q_retry_i,
    output logic [W-1:0] q_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    assign din_retry_o = valid_q && q_retry_i;
    assign q_valid_o   = valid_q;
    assign q_o         = data_q;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the pre-edge value of every other flop regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (din_valid_i && !din_retry_o) begin
            valid_q <= 1'b1;
            data_q  <= din_i;
        end else if (!q_retry_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/l1tlb_miss_tracker.sv
// L1TLB miss tracker: one entry per distinct in-flight page, one L2TLB request per entry,
// acks matched by rid and returned to the L1TLB array through a registered fill.
module l1tlb_miss_tracker
    import l1tlb_miss_tracker_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int RID_W   = L1TLB_RID_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      miss_valid,
    output logic                      miss_retry,
    input  logic [L1TLB_LADDR_W-1:0]  miss_laddr,
    output logic                      l1tlbtol2tlb_req_valid,
    input  logic                      l1tlbtol2tlb_req_retry,
    output logic [RID_W-1:0]          l1tlbtol2tlb_req_rid,
    output logic [L1TLB_LADDR_W-1:0]  l1tlbtol2tlb_req_laddr,
    input  logic                      l2tlbtol1tlb_ack_valid,
    output logic                      l2tlbtol1tlb_ack_retry,
    input  logic [RID_W-1:0]          l2tlbtol1tlb_ack_rid,
    input  logic [L1TLB_HPADDR_W-1:0] l2tlbtol1tlb_ack_hpaddr,
    input  logic [L1TLB_PPADDR_W-1:0] l2tlbtol1tlb_ack_ppaddr,
    input  logic [L1TLB_DCTLBE_W-1:0] l2tlbtol1tlb_ack_dctlbe,
    output logic                      fill_valid,
    input  logic                      fill_retry,
    output logic [L1TLB_VPN_W-1:0]    fill_vpn,
    output logic [L1TLB_HPADDR_W-1:0] fill_hpaddr,
    output logic [L1TLB_PPADDR_W-1:0] fill_ppaddr,
    output logic [L1TLB_DCTLBE_W-1:0] fill_dctlbe,
    output logic                      busy,
    output logic                      err_bad_rid
);

    l1tlb_mshr_state_t      state_q [ENTRIES];
    l1tlb_mshr_state_t      state_d [ENTRIES];
    logic [L1TLB_VPN_W-1:0] vpn_q   [ENTRIES];
    logic                   lock_q;
    logic [RID_W-1:0]       lock_rid_q;
    logic                   err_q;

    logic [L1TLB_VPN_W-1:0] miss_vpn;
    logic [L1TLB_PGOFF_W-1:0] unused_laddr_pgoff;
    I_l2tlbtol1tlb_ack_type ack;
    I_l1tlbtol2tlb_req_type req;
    l1tlb_fill_t            fill_in, fill_out;

    logic any_free, any_pend, any_match, any_busy;
    logic [RID_W-1:0] alloc_rid, pend_rid;
    logic ack_hit, ack_fire, ack_good, miss_alloc, req_fire;

    assign miss_vpn           = miss_laddr[L1TLB_LADDR_W-1:L1TLB_PGOFF_W];
    assign unused_laddr_pgoff = miss_laddr[L1TLB_PGOFF_W-1:0];

    assign ack = '{rid:    l2tlbtol1tlb_ack_rid,
                   hpaddr: l2tlbtol1tlb_ack_hpaddr,
                   ppaddr: l2tlbtol1tlb_ack_ppaddr,
                   dctlbe: l2tlbtol1tlb_ack_dctlbe};

    // Bad-rid acks are still accepted (ack_fire) but never reach the fill register.
    assign ack_hit  = (state_q[ack.rid] == WAIT);
    assign ack_fire = l2tlbtol1tlb_ack_valid && !l2tlbtol1tlb_ack_retry;
    assign ack_good = ack_fire && ack_hit;

    // NOTE: every always_comb output gets a default before any conditional update, so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        any_free  = 1'b0;
        any_pend  = 1'b0;
        any_match = 1'b0;
        any_busy  = 1'b0;
        alloc_rid = '0;
        pend_rid  = '0;
        // Descending scan so the lowest index is the last (winning) assignment.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (state_q[i] == FREE) begin
                any_free  = 1'b1;
                alloc_rid = RID_W'(i);
            end else begin
                any_busy = 1'b1;
            end
            if (state_q[i] == PEND) begin
                any_pend = 1'b1;
                pend_rid = RID_W'(i);
            end
            if (state_q[i] != FREE && vpn_q[i] == miss_vpn && !(ack_good && ack.rid == RID_W'(i)))
                any_match = 1'b1;
        end
    end

    assign miss_retry = !any_match && !any_free;
    assign miss_alloc = miss_valid && !any_match && any_free;

    assign req.rid   = lock_q ? lock_rid_q : pend_rid;
    assign req.laddr = vpn_to_laddr(vpn_q[req.rid]);
    assign req_fire  = any_pend && !l1tlbtol2tlb_req_retry;

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) state_d[i] = state_q[i];
        if (miss_alloc) state_d[alloc_rid] = PEND;
        if (req_fire)   state_d[req.rid]   = WAIT;
        if (ack_good)   state_d[ack.rid]   = FREE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) state_q[i] <= FREE;
            lock_q     <= 1'b0;
            lock_rid_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_q     <= any_pend && l1tlbtol2tlb_req_retry;
            lock_rid_q <= req.rid;
            err_q      <= err_q || (ack_fire && !ack_hit);
        end
    end

    // NOTE: the vpn array has no reset; an entry's vpn is only read while its state is
    // not FREE, and every allocation writes it first.
    always_ff @(posedge clk) begin
        if (miss_alloc) vpn_q[alloc_rid] <= miss_vpn;
    end

    assign fill_in = '{vpn:    vpn_q[ack.rid],
                       hpaddr: ack.hpaddr,
                       ppaddr: ack.ppaddr,
                       dctlbe: ack.dctlbe};

    l1tlb_miss_tracker_fflop #(
        .W($bits(l1tlb_fill_t))
    ) u_fill (
        .clk         (clk),
        .reset       (reset),
        .din_valid_i (l2tlbtol1tlb_ack_valid && ack_hit),
        .din_retry_o (l2tlbtol1tlb_ack_retry),
        .din_i       (fill_in),
        .q_valid_o   (fill_valid),
        .q_retry_i   (fill_retry),
        .q_o         (fill_out)
    );

    assign l1tlbtol2tlb_req_valid = any_pend;
    assign l1tlbtol2tlb_req_rid   = req.rid;
    assign l1tlbtol2tlb_req_laddr = req.laddr;
    assign fill_vpn               = fill_out.vpn;
    assign fill_hpaddr            = fill_out.hpaddr;
    assign fill_ppaddr            = fill_out.ppaddr;
    assign fill_dctlbe            = fill_out.dctlbe;
    assign busy                   = any_busy;
    assign err_bad_rid            = err_q;

endmodule

// File: tb/tb_l1tlb_miss_tracker.sv
// Directed bench for l1tlb_miss_tracker: single miss, merge, full, back-pressure, bad rid
// and mid-flight reset, with hand-computed expectations.
module tb_l1tlb_miss_tracker;

    logic        clk = 1'b0;
    logic        reset;
    logic        miss_valid;
    logic        miss_retry;
    logic [38:0] miss_laddr;
    logic        l1tlbtol2tlb_req_valid;
    logic        l1tlbtol2tlb_req_retry;
    logic [1:0]  l1tlbtol2tlb_req_rid;
    logic [38:0] l1tlbtol2tlb_req_laddr;
    logic        l2tlbtol1tlb_ack_valid;
    logic        l2tlbtol1tlb_ack_retry;
    logic [1:0]  l2tlbtol1tlb_ack_rid;
    logic [10:0] l2tlbtol1tlb_ack_hpaddr;
    logic [2:0]  l2tlbtol1tlb_ack_ppaddr;
    logic [12:0] l2tlbtol1tlb_ack_dctlbe;
    logic        fill_valid;
    logic        fill_retry;
    logic [26:0] fill_vpn;
    logic [10:0] fill_hpaddr;
    logic [2:0]  fill_ppaddr;
    logic [12:0] fill_dctlbe;
    logic        busy;
    logic        err_bad_rid;

    int n_vec = 0;
    int n_err = 0;

    l1tlb_miss_tracker #(.ENTRIES(4), .RID_W(2)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .miss_valid              (miss_valid),
        .miss_retry              (miss_retry),
        .miss_laddr              (miss_laddr),
        .l1tlbtol2tlb_req_valid  (l1tlbtol2tlb_req_valid),
        .l1tlbtol2tlb_req_retry  (l1tlbtol2tlb_req_retry),
        .l1tlbtol2tlb_req_rid    (l1tlbtol2tlb_req_rid),
        .l1tlbtol2tlb_req_laddr  (l1tlbtol2tlb_req_laddr),
        .l2tlbtol1tlb_ack_valid  (l2tlbtol1tlb_ack_valid),
        .l2tlbtol1tlb_ack_retry  (l2tlbtol1tlb_ack_retry),
        .l2tlbtol1tlb_ack_rid    (l2tlbtol1tlb_ack_rid),
        .l2tlbtol1tlb_ack_hpaddr (l2tlbtol1tlb_ack_hpaddr),
        .l2tlbtol1tlb_ack_ppaddr (l2tlbtol1tlb_ack_ppaddr),
        .l2tlbtol1tlb_ack_dctlbe (l2tlbtol1tlb_ack_dctlbe),
        .fill_valid              (fill_valid),
        .fill_retry              (fill_retry),
        .fill_vpn                (fill_vpn),
        .fill_hpaddr             (fill_hpaddr),
        .fill_ppaddr             (fill_ppaddr),
        .fill_dctlbe             (fill_dctlbe),
        .busy                    (busy),
        .err_bad_rid             (err_bad_rid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs set here apply at the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic miss(input logic [38:0] laddr);
        miss_valid = 1'b1;
        miss_laddr = laddr;
    endtask

    task automatic ack(input logic [1:0] rid, input logic [10:0] hp, input logic [2:0] pp,
                       input logic [12:0] dc);
        l2tlbtol1tlb_ack_valid  = 1'b1;
        l2tlbtol1tlb_ack_rid    = rid;
        l2tlbtol1tlb_ack_hpaddr = hp;
        l2tlbtol1tlb_ack_ppaddr = pp;
        l2tlbtol1tlb_ack_dctlbe = dc;
    endtask

    logic [1:0]  drain_rid [4];
    logic [26:0] drain_vpn [4];

    initial begin
        reset                   = 1'b1;
        miss_valid              = 1'b0;
        miss_laddr              = '0;
        l1tlbtol2tlb_req_retry  = 1'b0;
        l2tlbtol1tlb_ack_valid  = 1'b0;
        l2tlbtol1tlb_ack_rid    = '0;
        l2tlbtol1tlb_ack_hpaddr = '0;
        l2tlbtol1tlb_ack_ppaddr = '0;
        l2tlbtol1tlb_ack_dctlbe = '0;
        fill_retry              = 1'b0;
        #2;
        check("rst_req_valid", 64'(l1tlbtol2tlb_req_valid), 64'd0);
        check("rst_fill_valid", 64'(fill_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err_bad_rid), 64'd0);
        check("rst_miss_retry", 64'(miss_retry), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Single miss, request at N+1, ack, fill at M+1.
        miss(39'h12_3456_7000);
        settle();
        check("t1_miss_retry", 64'(miss_retry), 64'd0);
        check("t1_req_not_yet", 64'(l1tlbtol2tlb_req_valid), 64'd0);
        tick();
        miss_valid = 1'b0;
        settle();
        check("t1_req_valid", 64'(l1tlbtol2tlb_req_valid), 64'd1);
        check("t1_req_rid", 64'(l1tlbtol2tlb_req_rid), 64'd0);
        check("t1_req_laddr", 64'(l1tlbtol2tlb_req_laddr), 64'h12_3456_7000);
        check("t1_busy", 64'(busy), 64'd1);
        tick();
        check("t1_req_done", 64'(l1tlbtol2tlb_req_valid), 64'd0);
        ack(2'd0, 11'h155, 3'd5, 13'h1A3);
        settle();
        check("t1_ack_retry", 64'(l2tlbtol1tlb_ack_retry), 64'd0);
        tick();
        l2tlbtol1tlb_ack_valid = 1'b0;
        settle();
        check("t1_fill_valid", 64'(fill_valid), 64'd1);
        check("t1_fill_vpn", 64'(fill_vpn), 64'h123_4567);
        check("t1_fill_hpaddr", 64'(fill_hpaddr), 64'h155);
        check("t1_fill_ppaddr", 64'(fill_ppaddr), 64'd5);
        check("t1_fill_dctlbe", 64'(fill_dctlbe), 64'h1A3);
        check("t1_busy_drop", 64'(busy), 64'd0);
        tick();
        check("t1_fill_drained", 64'(fill_valid), 64'd0);

        // Merge: two misses to page 0x4, one request, one fill.
        miss(39'h4000);
        tick();
        miss(39'h4ABC);
        settle();
        check("t2_merge_accept", 64'(miss_retry), 64'd0);
        check("t2_req_rid", 64'(l1tlbtol2tlb_req_rid), 64'd0);
        tick();
        miss_valid = 1'b0;
        settle();
        check("t2_no_second_req", 64'(l1tlbtol2tlb_req_valid), 64'd0);
        ack(2'd0, 11'h011, 3'd1, 13'h0F0);
        tick();
        l2tlbtol1tlb_ack_valid = 1'b0;
        settle();
        check("t2_fill_vpn", 64'(fill_vpn), 64'h4);
        check("t2_fill_valid", 64'(fill_valid), 64'd1);
        check("t2_busy_drop", 64'(busy), 64'd0);
        tick();
        check("t2_single_fill", 64'(fill_valid), 64'd0);

        // Full: four distinct pages, fifth distinct retried, fifth matching merged.
        miss(39'h10_000);
        tick();
        miss(39'h11_000);
        settle();
        check("t3_req_rid0", 64'(l1tlbtol2tlb_req_rid), 64'd0);
        tick();
        miss(39'h12_000);
        settle();
        check("t3_req_rid1", 64'(l1tlbtol2tlb_req_rid), 64'd1);
        tick();
        miss(39'h13_000);
        settle();
        check("t3_req_rid2", 64'(l1tlbtol2tlb_req_rid), 64'd2);
        tick();
        miss(39'h14_000);
        settle();
        check("t3_full_retry", 64'(miss_retry), 64'd1);
        check("t3_req_rid3", 64'(l1tlbtol2tlb_req_rid), 64'd3);
        tick();
        miss(39'h11_5A0);
        settle();
        check("t3_inflight_merge", 64'(miss_retry), 64'd0);
        tick();
        // Miss to the page being freed this cycle must not merge, and nothing is free yet.
        miss(39'h12_000);
        ack(2'd2, 11'h222, 3'd2, 13'h002);
        settle();
        check("t3_freeing_no_merge", 64'(miss_retry), 64'd1);
        tick();
        l2tlbtol1tlb_ack_valid = 1'b0;
        miss(39'h14_000);
        settle();
        check("t3_fill_vpn2", 64'(fill_vpn), 64'h12);
        check("t3_realloc_accept", 64'(miss_retry), 64'd0);
        tick();
        miss_valid = 1'b0;
        settle();
        check("t3_realloc_rid", 64'(l1tlbtol2tlb_req_rid), 64'd2);
        check("t3_realloc_laddr", 64'(l1tlbtol2tlb_req_laddr), 64'h14_000);
        check("t3_fill_drained", 64'(fill_valid), 64'd0);
        tick();
        drain_rid = '{2'd0, 2'd1, 2'd3, 2'd2};
        drain_vpn = '{27'h10, 27'h11, 27'h13, 27'h14};
        for (int k = 0; k < 4; k++) begin
            ack(drain_rid[k], 11'h300 + 11'(k), 3'd0, 13'd0);
            tick();
            l2tlbtol1tlb_ack_valid = 1'b0;
            check("t3_drain_valid", 64'(fill_valid), 64'd1);
            check("t3_drain_vpn", 64'(fill_vpn), 64'(drain_vpn[k]));
            check("t3_drain_hpaddr", 64'(fill_hpaddr), 64'h300 + 64'(k));
        end
        check("t3_all_free", 64'(busy), 64'd0);
        tick();
        check("t3_fill_empty", 64'(fill_valid), 64'd0);

        // Back-pressure setup: entries 0 and 2 WAIT, 1 and 3 FREE.
        miss(39'h20_000);
        tick();
        miss(39'h21_000);
        tick();
        miss(39'h22_000);
        tick();
        miss_valid = 1'b0;
        ack(2'd1, 11'h021, 3'd0, 13'd0);
        tick();
        l2tlbtol1tlb_ack_valid = 1'b0;
        l1tlbtol2tlb_req_retry = 1'b1;
        miss(39'h31_000);
        tick();
        miss(39'h33_000);
        settle();
        check("t4_hold_rid_c1", 64'(l1tlbtol2tlb_req_rid), 64'd1);
        tick();
        miss_valid = 1'b0;
        settle();
        check("t4_hold_rid_c2", 64'(l1tlbtol2tlb_req_rid), 64'd1);
        tick();
        check("t4_hold_rid_c3", 64'(l1tlbtol2tlb_req_rid), 64'd1);
        check("t4_hold_valid", 64'(l1tlbtol2tlb_req_valid), 64'd1);
        tick();
        l1tlbtol2tlb_req_retry = 1'b0;
        settle();
        check("t4_issue_rid1", 64'(l1tlbtol2tlb_req_rid), 64'd1);
        check("t4_issue_laddr1", 64'(l1tlbtol2tlb_req_laddr), 64'h31_000);
        tick();
        check("t4_issue_rid3", 64'(l1tlbtol2tlb_req_rid), 64'd3);
        check("t4_issue_laddr3", 64'(l1tlbtol2tlb_req_laddr), 64'h33_000);
        tick();
        check("t4_issue_done", 64'(l1tlbtol2tlb_req_valid), 64'd0);

        // Fill back-pressure: second ack is held off until the fill drains.
        fill_retry = 1'b1;
        ack(2'd0, 11'h0A0, 3'd3, 13'h100);
        settle();
        check("t4_ack0_accept", 64'(l2tlbtol1tlb_ack_retry), 64'd0);
        tick();
        ack(2'd2, 11'h0A2, 3'd4, 13'h102);
        settle();
        check("t4_ack_retry_c1", 64'(l2tlbtol1tlb_ack_retry), 64'd1);
        check("t4_fill_vpn0_c1", 64'(fill_vpn), 64'h20);
        tick();
        check("t4_ack_retry_c2", 64'(l2tlbtol1tlb_ack_retry), 64'd1);
        check("t4_fill_vpn0_c2", 64'(fill_vpn), 64'h20);
        check("t4_fill_hp0_c2", 64'(fill_hpaddr), 64'h0A0);
        tick();
        fill_retry = 1'b0;
        settle();
        check("t4_ack_release", 64'(l2tlbtol1tlb_ack_retry), 64'd0);
        tick();
        check("t4_fill_vpn2", 64'(fill_vpn), 64'h22);
        check("t4_fill_hp2", 64'(fill_hpaddr), 64'h0A2);
        check("t4_fill_dc2", 64'(fill_dctlbe), 64'h102);
        ack(2'd1, 11'h0A1, 3'd0, 13'd0);
        tick();
        check("t4_fill_vpn1", 64'(fill_vpn), 64'h31);
        ack(2'd3, 11'h0A3, 3'd0, 13'd0);
        tick();
        l2tlbtol1tlb_ack_valid = 1'b0;
        check("t4_fill_vpn3", 64'(fill_vpn), 64'h33);
        check("t4_all_free", 64'(busy), 64'd0);
        check("t4_no_err", 64'(err_bad_rid), 64'd0);
        tick();

        // Bad rid: ack to a FREE entry is dropped and sets the sticky error.
        ack(2'd3, 11'h7FF, 3'd7, 13'h1FFF);
        settle();
        check("t5_bad_accepted", 64'(l2tlbtol1tlb_ack_retry), 64'd0);
        tick();
        l2tlbtol1tlb_ack_valid = 1'b0;
        check("t5_no_fill", 64'(fill_valid), 64'd0);
        check("t5_err_set", 64'(err_bad_rid), 64'd1);
        check("t5_busy", 64'(busy), 64'd0);
        tick();
        tick();
        check("t5_err_sticky", 64'(err_bad_rid), 64'd1);

        // Reset mid-flight with two WAIT entries.
        miss(39'h50_000);
        tick();
        miss(39'h51_000);
        tick();
        miss_valid = 1'b0;
        tick();
        check("t6_busy_before", 64'(busy), 64'd1);
        check("t6_req_idle", 64'(l1tlbtol2tlb_req_valid), 64'd0);
        reset = 1'b1;
        settle();
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_err", 64'(err_bad_rid), 64'd0);
        check("t6_rst_req", 64'(l1tlbtol2tlb_req_valid), 64'd0);
        check("t6_rst_fill", 64'(fill_valid), 64'd0);
        check("t6_rst_miss_retry", 64'(miss_retry), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        miss(39'h60_000);
        settle();
        check("t6_post_accept", 64'(miss_retry), 64'd0);
        tick();
        miss_valid = 1'b0;
        settle();
        check("t6_post_req_valid", 64'(l1tlbtol2tlb_req_valid), 64'd1);
        check("t6_post_rid", 64'(l1tlbtol2tlb_req_rid), 64'd0);
        check("t6_post_laddr", 64'(l1tlbtol2tlb_req_laddr), 64'h60_000);
        tick();
        ack(2'd1, 11'h001, 3'd1, 13'd1);
        tick();
        l2tlbtol1tlb_ack_valid = 1'b0;
        check("t6_stale_ack_err", 64'(err_bad_rid), 64'd1);
        check("t6_stale_ack_nofill", 64'(fill_valid), 64'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
